// File: rtl/swacc_cm_cmd_dispatch.sv
// CEU context-command demux: buffers the incoming beat stream in a 2-entry skid buffer and routes
// each whole packet to one CxtMgt thread chosen by the first-beat opcode; unmapped packets are drained.
module swacc_cm_cmd_dispatch #(
  parameter int          NUM_CH    = 4,
  parameter int          HEAD_W    = 128,
  parameter int          DATA_W    = 256,
  parameter int          OPC_LSB   = 124,
  parameter logic [63:0] ROUTE_MAP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [HEAD_W-1:0]          in_head,
  input  logic                       in_last,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic [NUM_CH-1:0]          out_valid,
  output logic [NUM_CH*HEAD_W-1:0]   out_head,
  output logic [NUM_CH-1:0]          out_last,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  input  logic [NUM_CH-1:0]          out_ready,
  output logic                       drop_pulse,
  output logic [15:0]                drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

  typedef struct packed {
    logic [HEAD_W-1:0] head;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [1:0]  state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        drop_pulse_q, drop_pulse_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  beat_t       e0_q, e0_d, e1_q, e1_d;

  logic        bh_valid, push, pop, sel_ready, route_drop;
  logic [3:0]  opcode, route_ch;
  beat_t       in_beat;

  assign in_beat  = '{head: in_head, last: in_last, data: in_data};
  assign bh_valid = (cnt_q != 2'd0);
  assign opcode   = e0_q.head[OPC_LSB +: 4];
  assign route_ch = ROUTE_MAP[{opcode, 2'b00} +: 4];
  assign route_drop = (route_ch == 4'hF) || (route_ch >= NUM_CH_L);
  assign push     = in_valid && in_ready_q;

  // Route decision, pop and drop accounting.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    sel_ready    = 1'b0;
    pop          = 1'b0;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_q == 4'(c)) sel_ready = out_ready[c];
    end
    case (state_q)
      ST_IDLE: begin
        if (bh_valid) begin
          if (route_drop) begin
            state_d = ST_DROP;
          end else begin
            sel_d   = route_ch;
            state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        pop = bh_valid && sel_ready;
        if (pop && e0_q.last) state_d = ST_IDLE;
      end
      ST_DROP: begin
        pop = bh_valid;
        if (pop && e0_q.last) begin
          state_d      = ST_IDLE;
          drop_pulse_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid buffer: entry 0 is always the oldest beat; occupancy never exceeds 2.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = in_beat;
        else               e1_d = in_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = in_beat;
        end else begin
          e0_d = e1_q;
          e1_d = in_beat;
        end
      end
      default: ;
    endcase
    in_ready_d = (cnt_d != 2'd2);
  end

  always_comb begin
    out_valid = '0;
    out_last  = '0;
    out_head  = '0;
    out_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_q == ST_FWD && sel_q == 4'(c)) begin
        out_valid[c]                  = bh_valid;
        out_last[c]                   = e0_q.last;
        out_head[c*HEAD_W +: HEAD_W]  = e0_q.head;
        out_data[c*DATA_W +: DATA_W]  = e0_q.data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 4'd0;
      cnt_q        <= 2'd0;
      in_ready_q   <= 1'b1;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // NOTE: payload storage is not reset; cnt_q qualifies it and outputs are gated by the FSM.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign in_ready   = in_ready_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_swacc_cm_cmd_dispatch.sv
// Scoreboard bench for swacc_cm_cmd_dispatch: expected beats are queued per channel when driven
// and compared when the sink takes them; a second NUM_CH=2 instance covers out-of-range routes.
module tb_swacc_cm_cmd_dispatch;

  localparam int          HW  = 128;
  localparam int          DW  = 256;
  localparam logic [63:0] MAP = 64'hFFFF_FFFF_3F32_100F;

  typedef struct {
    logic [HW-1:0] head;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic            in_valid = 1'b0;
  logic [HW-1:0]   in_head  = '0;
  logic            in_last  = 1'b0;
  logic [DW-1:0]   in_data  = '0;
  logic            in_ready;
  logic [3:0]      out_valid;
  logic [4*HW-1:0] out_head;
  logic [3:0]      out_last;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_ready = 4'hF;
  logic            drop_pulse;
  logic [15:0]     drop_cnt;

  logic            in2_valid = 1'b0;
  logic [HW-1:0]   in2_head  = '0;
  logic            in2_last  = 1'b0;
  logic [DW-1:0]   in2_data  = '0;
  logic            in2_ready;
  logic [1:0]      out2_valid;
  logic [2*HW-1:0] out2_head;
  logic [1:0]      out2_last;
  logic [2*DW-1:0] out2_data;
  logic [1:0]      out2_ready = 2'b11;
  logic            drop_pulse2;
  logic [15:0]     drop_cnt2;

  swacc_cm_cmd_dispatch #(.NUM_CH(4), .HEAD_W(HW), .DATA_W(DW), .OPC_LSB(124), .ROUTE_MAP(MAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_head(in_head), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_head(out_head),
    .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt));

  swacc_cm_cmd_dispatch #(.NUM_CH(2), .HEAD_W(HW), .DATA_W(DW), .OPC_LSB(124), .ROUTE_MAP(MAP)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in2_valid), .in_head(in2_head), .in_last(in2_last),
    .in_data(in2_data), .in_ready(in2_ready), .out_valid(out2_valid), .out_head(out2_head),
    .out_last(out2_last), .out_data(out2_data), .out_ready(out2_ready),
    .drop_pulse(drop_pulse2), .drop_cnt(drop_cnt2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  beat_t sbq[4][$];
  int    xfer_times[$];
  int    exp_drops = 0;
  int    pulses = 0;
  int    pulses2 = 0;
  logic  pulse_prev = 1'b0;
  logic  inr_low = 1'b0;
  logic  seen2 = 1'b0;
  logic  stall_q[4];
  logic [HW+DW:0] snap[4];
  int    nv;
  beat_t mb;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent model of the route table for a NUM_CH-channel instance; -1 means drop.
  function automatic int model_route(input logic [3:0] op, input int nch);
    int ch;
    case (op)
      4'd1, 4'd2: ch = 0;
      4'd3:       ch = 1;
      4'd4:       ch = 2;
      4'd5, 4'd7: ch = 3;
      default:    ch = -1;
    endcase
    if (ch >= nch) ch = -1;
    return ch;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [HW-1:0] rand_head(input logic [3:0] op);
    logic [HW-1:0] h;
    for (int i = 0; i < HW/32; i++) h[i*32 +: 32] = $urandom;
    h[127:124] = op;
    return h;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard pops, exclusivity, stall stability and drop pulse tracking.
  always @(negedge clk) begin
    if (!rst) begin
      nv = $countones(out_valid);
      if (nv != 0) check("onehot", nv, 1);
      for (int c = 0; c < 4; c++) begin
        if (stall_q[c]) begin
          check("stall_valid", out_valid[c], 1'b1);
          check("stall_payload", snap[c] == {out_head[c*HW +: HW], out_last[c], out_data[c*DW +: DW]}, 1'b1);
        end
        if (nv != 0 && !out_valid[c])
          check("others_zero", (|out_head[c*HW +: HW]) | (|out_data[c*DW +: DW]) | out_last[c], 1'b0);
        if (out_valid[c] && out_ready[c]) begin
          check("expected_beat", sbq[c].size() != 0, 1'b1);
          if (sbq[c].size() != 0) begin
            mb = sbq[c].pop_front();
            check("head", out_head[c*HW +: HW], mb.head);
            check("data", out_data[c*DW +: DW], mb.data);
            check("last", out_last[c], mb.last);
          end
          xfer_times.push_back(cyc);
        end
        stall_q[c] = out_valid[c] && !out_ready[c];
        snap[c]    = {out_head[c*HW +: HW], out_last[c], out_data[c*DW +: DW]};
      end
      if (drop_pulse) begin
        check("pulse_width", pulse_prev, 1'b0);
        pulses++;
      end
      pulse_prev = drop_pulse;
      if (!in_ready) inr_low = 1'b1;
      if (|out2_valid) seen2 = 1'b1;
      if (drop_pulse2) pulses2++;
    end else begin
      for (int c = 0; c < 4; c++) stall_q[c] = 1'b0;
      pulse_prev = 1'b0;
    end
  end

  task automatic send_beat(input logic [HW-1:0] h, input logic [DW-1:0] d, input logic l);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_head  = h;
    in_data  = d;
    in_last  = l;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("in_accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] op, input int nb);
    int    ch;
    beat_t b;
    ch = model_route(op, 4);
    for (int i = 0; i < nb; i++) begin
      b.head = (i == 0) ? rand_head(op) : rand_head(4'($urandom_range(0, 15)));
      b.data = rand_data();
      b.last = (i == nb - 1);
      if (ch >= 0) sbq[ch].push_back(b);
      send_beat(b.head, b.data, b.last);
    end
    if (ch < 0) exp_drops++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses_before, n;
    logic acc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_out_last", out_last, 4'h0);
    check("rst_out_zero", (|out_head) | (|out_data), 1'b0);
    check("rst_drop", {drop_pulse, drop_cnt}, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: op3 four beats on ch1
    send_pkt(4'd3, 4);
    drain();

    // 2: op1 three beats with ch0 ready toggling
    inr_low = 1'b0;
    begin
      logic done;
      done = 1'b0;
      fork
        begin
          send_pkt(4'd1, 3);
          done = 1'b1;
        end
        begin
          n = 0;
          while ((!done || sbq[0].size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            out_ready[0] = ~out_ready[0];
            n++;
          end
        end
      join
    end
    out_ready = 4'hF;
    drain();
    check("in_ready_backpressure", inr_low, 1'b1);

    // 3: dropped op9 packet followed by op4 single beat
    pulses_before = pulses;
    send_pkt(4'd9, 5);
    send_pkt(4'd4, 1);
    drain();
    check("drop_pulses_t3", pulses - pulses_before, 1);
    check("drop_cnt_t3", drop_cnt, 16'(exp_drops));

    // 5: back-to-back single-beat packets, 2 cycles each
    xfer_times.delete();
    send_pkt(4'd1, 1);
    send_pkt(4'd3, 1);
    send_pkt(4'd1, 1);
    drain();
    check("t5_xfers", xfer_times.size(), 3);
    if (xfer_times.size() == 3) begin
      check("t5_gap0", xfer_times[1] - xfer_times[0], 2);
      check("t5_gap1", xfer_times[2] - xfer_times[1], 2);
    end

    // 6: reset during beat 2 of a 4-beat op4 packet (ch2 held stalled)
    out_ready = 4'b1011;
    send_beat(rand_head(4'd4), rand_data(), 1'b0);
    send_beat(rand_head(4'd2), rand_data(), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_out_valid", out_valid, 4'h0);
    check("t6_out_last", out_last, 4'h0);
    check("t6_out_zero", (|out_head) | (|out_data), 1'b0);
    check("t6_drop_cnt", drop_cnt, 16'd0);
    check("t6_in_ready", in_ready, 1'b1);
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 4'hF;
    @(posedge clk);
    #1;
    send_pkt(4'd3, 2);
    drain();
    check("t6_drop_after", drop_cnt, 16'(exp_drops));

    // 4: NUM_CH=2 instance, op5 maps to channel 3 -> dropped
    seen2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in2_valid = 1'b1;
      in2_head  = rand_head(4'd5);
      in2_data  = rand_data();
      in2_last  = (i == 1);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = in2_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) check("in2_accept_timeout", 1'b0, 1'b1);
      in2_valid = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    check("t4_no_valid", seen2, 1'b0);
    check("t4_drop_cnt", drop_cnt2, 16'd1);
    check("t4_pulses", pulses2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
